// File: rtl/systolic_operand_loader_pkg.sv
// rtl/systolic_operand_loader_pkg.sv - shared types and sizes for the systolic operand loader
// SYSTOLIC_LOADER_CKSUM_EN adds a trailing XOR checksum byte to every pair.
package systolic_operand_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam int OPW   = 16;
  localparam int CNT_W = 3;

`ifdef SYSTOLIC_LOADER_CKSUM_EN
  localparam int N_BYTES = 5;
`else
  localparam int N_BYTES = 4;
`endif

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BYTES - 1);

  // Data bytes occupy slots 0..3; slot 4, when present, is the checksum.
  function automatic logic is_data_slot(input logic [CNT_W-1:0] cnt);
    return cnt < CNT_W'(4);
  endfunction

endpackage

// File: rtl/systolic_operand_loader_byte_shift.sv
// rtl/systolic_operand_loader_byte_shift.sv - byte placement register feeding operands A and B
// Slot index selects word (bit 1) and byte lane (bit 0, swapped when MSB_FIRST).
module sys_byte_shift
  import systolic_operand_loader_pkg::*;
#(
  parameter int MSB_FIRST = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_en,
  input  logic [1:0]     i_idx,
  input  logic [7:0]     i_byte,
  output logic [OPW-1:0] o_a,
  output logic [OPW-1:0] o_b
);

  logic [OPW-1:0] r_a;
  logic [OPW-1:0] r_b;
  logic           w_hi;

  assign w_hi = i_idx[0] ^ (MSB_FIRST != 0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
    end else if (i_en) begin
      case ({i_idx[1], w_hi})
        2'b00:   r_a[7:0]  <= i_byte;
        2'b01:   r_a[15:8] <= i_byte;
        2'b10:   r_b[7:0]  <= i_byte;
        default: r_b[15:8] <= i_byte;
      endcase
    end
  end

  assign o_a = r_a;
  assign o_b = r_b;

endmodule

// File: rtl/systolic_operand_loader.sv
// rtl/systolic_operand_loader.sv - assembles byte strobes into A/B operand pairs for a systolic PE
// SYSTOLIC_LOADER_CKSUM_EN: a fifth XOR byte must match or the pair is discarded.
module systolic_operand_loader
  import systolic_operand_loader_pkg::*;
#(
  parameter int MSB_FIRST = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  input  logic [7:0]     in_byte,
  input  logic           in_strobe,
  input  logic           out_ready,
  input  logic           err_clr,
  output logic [OPW-1:0] a_word,
  output logic [OPW-1:0] b_word,
  output logic           out_valid,
  output logic           busy,
  output logic           err_overrun,
  output logic           err_cksum
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid;
  logic             r_busy;
  logic             r_err_ov;

  logic             w_hold;
  logic             w_accept;
  logic             w_cap;
  logic             w_ov_set;

  assign w_hold   = (r_state == ST_HOLD);
  // The counter sits at 0 in IDLE and HOLD, so it always names the slot of the next byte.
  assign w_accept = ena & in_strobe & (~w_hold | out_ready);
  assign w_cap    = w_accept & is_data_slot(r_cnt);
  assign w_ov_set = ena & in_strobe & w_hold & ~out_ready;

`ifdef SYSTOLIC_LOADER_CKSUM_EN
  logic [7:0] r_cksum;
  logic       r_err_ck;
  logic       w_ck_bad;
  logic       w_ck_set;

  assign w_ck_bad  = ((r_cksum ^ in_byte) != 8'h00);
  assign w_ck_set  = ena & in_strobe & (r_state == ST_LOAD) & (r_cnt == LAST_CNT) & w_ck_bad;
  assign err_cksum = r_err_ck;
`else
  assign err_cksum = 1'b0;
`endif

  sys_byte_shift #(
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_cap),
    .i_idx  (r_cnt[1:0]),
    .i_byte (in_byte),
    .o_a    (a_word),
    .o_b    (b_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_err_ov <= 1'b0;
`ifdef SYSTOLIC_LOADER_CKSUM_EN
      r_cksum  <= 8'h00;
      r_err_ck <= 1'b0;
`endif
    end else if (ena) begin
      r_err_ov <= w_ov_set | (r_err_ov & ~err_clr);
`ifdef SYSTOLIC_LOADER_CKSUM_EN
      r_err_ck <= w_ck_set | (r_err_ck & ~err_clr);
`endif
      case (r_state)
        ST_IDLE: begin
          if (in_strobe) begin
            r_state <= ST_LOAD;
            r_cnt   <= CNT_W'(1);
            r_busy  <= 1'b1;
`ifdef SYSTOLIC_LOADER_CKSUM_EN
            r_cksum <= in_byte;
`endif
          end
        end
        ST_LOAD: begin
          if (in_strobe) begin
            if (r_cnt == LAST_CNT) begin
              r_cnt  <= '0;
              r_busy <= 1'b0;
`ifdef SYSTOLIC_LOADER_CKSUM_EN
              if (w_ck_bad) begin
                r_state <= ST_IDLE;
              end else begin
                r_state <= ST_HOLD;
                r_valid <= 1'b1;
              end
`else
              r_state <= ST_HOLD;
              r_valid <= 1'b1;
`endif
            end else begin
              r_cnt   <= r_cnt + 1'b1;
`ifdef SYSTOLIC_LOADER_CKSUM_EN
              r_cksum <= r_cksum ^ in_byte;
`endif
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            // A strobe coinciding with the transfer starts the next pair rather than being lost.
            if (in_strobe) begin
              r_state <= ST_LOAD;
              r_cnt   <= CNT_W'(1);
              r_busy  <= 1'b1;
`ifdef SYSTOLIC_LOADER_CKSUM_EN
              r_cksum <= in_byte;
`endif
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid   = r_valid;
  assign busy        = r_busy;
  assign err_overrun = r_err_ov;

endmodule

// File: tb/tb_systolic_operand_loader.sv
// tb/tb_systolic_operand_loader.sv - scoreboard bench for the systolic operand loader
// Builds with or without SYSTOLIC_LOADER_CKSUM_EN; the model follows the same macro.
module tb_systolic_operand_loader;
  import systolic_operand_loader_pkg::*;

  localparam int MP = 0;
  localparam int NB = N_BYTES;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
  } pair_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_strobe = 1'b0;
  logic        out_ready = 1'b0;
  logic        err_clr = 1'b0;
  logic [15:0] a_word;
  logic [15:0] b_word;
  logic        out_valid;
  logic        busy;
  logic        err_overrun;
  logic        err_cksum;

  int errors = 0;
  int checks = 0;

  logic [7:0] m_bytes[$];
  pair_t      q_exp[$];
  bit         m_hold = 0;
  bit         m_ov = 0;
  bit         m_ck = 0;

  systolic_operand_loader #(.MSB_FIRST(MP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .in_byte     (in_byte),
    .in_strobe   (in_strobe),
    .out_ready   (out_ready),
    .err_clr     (err_clr),
    .a_word      (a_word),
    .b_word      (b_word),
    .out_valid   (out_valid),
    .busy        (busy),
    .err_overrun (err_overrun),
    .err_cksum   (err_cksum)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural reference: a pair is the first NB accepted bytes, held until taken.
  function automatic void model_step(bit s, logic [7:0] d, bit r, bit e, bit c);
    bit set_ov = 0;
    bit set_ck = 0;
    logic [7:0] x;
    pair_t p;
    if (!e) return;
    if (m_hold) begin
      if (r) begin
        m_hold = 0;
        if (s) m_bytes.push_back(d);
      end else if (s) begin
        set_ov = 1;
      end
    end else if (s) begin
      m_bytes.push_back(d);
      if (m_bytes.size() == NB) begin
        x = 8'h00;
        foreach (m_bytes[i]) x = x ^ m_bytes[i];
        if (NB == 5 && x != 8'h00) begin
          set_ck = 1;
        end else begin
          p.a = (MP != 0) ? {m_bytes[0], m_bytes[1]} : {m_bytes[1], m_bytes[0]};
          p.b = (MP != 0) ? {m_bytes[2], m_bytes[3]} : {m_bytes[3], m_bytes[2]};
          q_exp.push_back(p);
          m_hold = 1;
        end
        m_bytes.delete();
      end
    end
    m_ov = set_ov | (m_ov & !c);
    m_ck = set_ck | (m_ck & !c);
  endfunction

  // Monitor: every handshake the DUT presents must match the oldest expected pair.
  always @(negedge clk) begin
    pair_t p;
    if (rst_n && ena && out_valid && out_ready) begin
      if (q_exp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pair: got a=%0h b=%0h expected no pair", a_word, b_word);
      end else begin
        p = q_exp.pop_front();
        check("pair_a", a_word, p.a);
        check("pair_b", b_word, p.b);
      end
    end
  end

  task automatic check_state();
    check("busy", busy, (m_bytes.size() > 0 && !m_hold));
    check("out_valid", out_valid, m_hold);
    check("err_overrun", err_overrun, m_ov);
    check("err_cksum", err_cksum, m_ck);
    if (m_hold && q_exp.size() > 0) begin
      check("held_a", a_word, q_exp[0].a);
      check("held_b", b_word, q_exp[0].b);
    end
  endtask

  task automatic step(bit s, logic [7:0] d, bit r, bit e, bit c);
    in_strobe = s;
    in_byte   = d;
    out_ready = r;
    ena       = e;
    err_clr   = c;
    model_step(s, d, r, e, c);
    @(posedge clk);
    #2;
    check_state();
  endtask

  task automatic do_reset();
    in_strobe = 0;
    out_ready = 0;
    err_clr   = 0;
    rst_n     = 0;
    #1;
    m_bytes.delete();
    q_exp.delete();
    m_hold = 0;
    m_ov = 0;
    m_ck = 0;
    check("rst_a", a_word, 16'h0000);
    check("rst_b", b_word, 16'h0000);
    check("rst_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ov", err_overrun, 1'b0);
    check("rst_ck", err_cksum, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1;
    ena   = 1;
  endtask

  task automatic send_pair(logic [7:0] b0, logic [7:0] b1, logic [7:0] b2, logic [7:0] b3);
    step(1, b0, 0, 1, 0);
    step(1, b1, 0, 1, 0);
    step(1, b2, 0, 1, 0);
    step(1, b3, 0, 1, 0);
    if (NB == 5) step(1, b0 ^ b1 ^ b2 ^ b3, 0, 1, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && m_hold; i++) step(0, 8'h00, 1, 1, 0);
  endtask

  initial begin
    logic [7:0] d;
    #2;
    do_reset();

    send_pair(8'h34, 8'h12, 8'h78, 8'h56);
    check("pair1_a", a_word, 16'h1234);
    check("pair1_b", b_word, 16'h5678);
    check("pair1_valid", out_valid, 1'b1);

    step(1, 8'hAA, 0, 1, 0);
    check("overrun_set", err_overrun, 1'b1);
    check("overrun_keep_a", a_word, 16'h1234);
    step(0, 8'h00, 0, 1, 1);
    check("overrun_clr", err_overrun, 1'b0);

    step(1, 8'h01, 1, 1, 0);
    check("backtoback_busy", busy, 1'b1);
    check("backtoback_lo", a_word[7:0], 8'h01);

    step(1, 8'h02, 0, 1, 0);
    step(1, 8'hFF, 0, 0, 0);
    step(0, 8'hEE, 0, 0, 0);
    step(1, 8'hEE, 1, 0, 0);
    step(1, 8'h03, 0, 1, 0);
    step(1, 8'h04, 0, 1, 0);
    if (NB == 5) step(1, 8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04, 0, 1, 0);
    check("ena_pair_a", a_word, 16'h0201);
    check("ena_pair_b", b_word, 16'h0403);
    drain();

    step(1, 8'h11, 0, 1, 0);
    step(1, 8'h22, 0, 1, 0);
    do_reset();
    send_pair(8'hAA, 8'hBB, 8'hCC, 8'hDD);
    check("post_rst_a", a_word, 16'hBBAA);
    check("post_rst_b", b_word, 16'hDDCC);
    drain();

`ifdef SYSTOLIC_LOADER_CKSUM_EN
    step(1, 8'h34, 0, 1, 0);
    step(1, 8'h12, 0, 1, 0);
    step(1, 8'h78, 0, 1, 0);
    step(1, 8'h56, 0, 1, 0);
    step(1, 8'h08, 0, 1, 0);
    check("ck_good_valid", out_valid, 1'b1);
    drain();
    step(1, 8'h34, 0, 1, 0);
    step(1, 8'h12, 0, 1, 0);
    step(1, 8'h78, 0, 1, 0);
    step(1, 8'h56, 0, 1, 0);
    step(1, 8'h09, 0, 1, 0);
    check("ck_bad_valid", out_valid, 1'b0);
    check("ck_bad_flag", err_cksum, 1'b1);
    step(0, 8'h00, 0, 1, 1);
`endif

    for (int n = 0; n < 400; n++) begin
      d = 8'($urandom);
      if (NB == 5 && !m_hold && m_bytes.size() == NB - 1 && $urandom_range(0, 3) != 0) begin
        d = 8'h00;
        foreach (m_bytes[i]) d = d ^ m_bytes[i];
      end
      step(bit'($urandom_range(0, 1)), d, $urandom_range(0, 9) < 3,
           $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0);
    end
    drain();
    check("queue_empty", q_exp.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/systolic_operand_loader.md
SYSTOLIC_OPERAND_LOADER -- requirements
Module: systolic_operand_loader

Interface
REQ-001 Parameter: MSB_FIRST, default 0, byte order within each 16-bit word (0 = low byte first, 1 = high byte first).
REQ-002 Port: clk  input  1  single clock; all state on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: ena  input  1  block enable; low stalls all state.
REQ-005 Port: in_byte  input  8  byte from the dedicated input pins.
REQ-006 Port: in_strobe  input  1  in_byte valid this cycle; no back-pressure on this side.
REQ-007 Port: out_ready  input  1  systolic PE accepts the operand pair.
REQ-008 Port: err_clr  input  1  clears the sticky error flags.
REQ-009 Port: a_word  output  16  operand A to the PE.
REQ-010 Port: b_word  output  16  operand B to the PE.
REQ-011 Port: out_valid  output  1  a_word/b_word hold a complete pair.
REQ-012 Port: busy  output  1  partial pair in assembly.
REQ-013 Port: err_overrun  output  1  sticky; a strobe was dropped.
REQ-014 Port: err_cksum  output  1  sticky; checksum mismatch (see Configuration).

Function
REQ-015 The FSM SHALL have states IDLE, LOAD and HOLD, with a byte counter 0..N-1, where N = 4 (5 with the checksum feature).
REQ-016 The byte sequence SHALL be A byte 0, A byte 1, B byte 0, B byte 1, placed per MSB_FIRST.
REQ-017 IDLE + strobe: capture byte 0, counter=1, go to LOAD; busy=1 next cycle.
REQ-018 LOAD + strobe: capture the byte and increment; on byte N-1, go to HOLD with out_valid=1 the next cycle (latency 1 clock after the last strobe).
REQ-019 a_word/b_word SHALL be stable while out_valid=1 and SHALL update only on capture.
REQ-020 HOLD + out_ready: the pair transfers and the FSM goes to IDLE.
REQ-021 HOLD + out_ready + strobe in the same cycle: the byte is captured as byte 0 of the next pair and the FSM goes to LOAD, with no drop.
REQ-022 HOLD + strobe without out_ready: the byte is dropped, err_overrun is set, and the held pair is unchanged.
REQ-023 ena=0: strobes are ignored, no error is raised, all state and outputs hold, and out_ready is ignored.
REQ-024 err_clr SHALL clear both flags next cycle; a simultaneous set SHALL win over the clear.
REQ-025 busy SHALL be 1 only in LOAD; out_valid SHALL be 1 only in HOLD.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, counter=0, a_word=b_word=0, out_valid=busy=0 and err_overrun=err_cksum=0.
REQ-027 Reset mid-LOAD or mid-HOLD SHALL discard the partial or held pair; the first strobe after release is byte 0.

Configuration
REQ-028 Macro SYSTOLIC_LOADER_CKSUM_EN defined: N=5, and byte 4 is the XOR of bytes 0..3.
- Match: the FSM goes to HOLD.
- Mismatch: the pair is discarded, the FSM returns to IDLE, out_valid stays 0 and err_cksum is set.
REQ-029 Macro undefined: N=4, no checksum logic, err_cksum tied to 0.

Structure
REQ-030 The shared systolic package SHALL hold the FSM state enum, the byte-count width constant and the operand width constant (16).
REQ-031 The single sub-module sys_byte_shift SHALL be a byte-wide shift/placement register with a capture enable; checksum XOR is inline.

Verification
REQ-032 Reset, then strobe 34,12,78,56 (hex) with MSB_FIRST=0 and out_ready=0 -> a_word=1234, b_word=5678, out_valid=1 one clock after the 4th strobe.
REQ-033 While holding, strobe 0xAA without out_ready -> err_overrun=1 and the pair is unchanged; err_clr pulse -> err_overrun=0.
REQ-034 out_ready and strobe 0x01 in the same cycle -> pair transfers, busy=1 next cycle, and the next pair's A low byte is 01.
REQ-035 ena=0 during bytes 2-3, with strobes toggling -> no capture and counter held; after ena=1, the pair completes with the correct values.
REQ-036 rst_n pulsed after 2 bytes -> outputs 0 and IDLE; 4 new bytes form a correct pair.
REQ-037 With CKSUM_EN: bytes 34,12,78,56,08 -> out_valid=1; last byte 09 -> out_valid stays 0 and err_cksum=1.
